frame_sampler: RTL and testbench
================================

FRAME_SAMPLER -- requirements
Module: frame_sampler

Interface
REQ-001 Parameter N, default 16: samples per frame; power of two, >= 2.
REQ-002 Parameter CH, default 1: channels strobed per sample tick; >= 1.
REQ-003 Parameter DIV_W, default 16: width of the runtime period input.
REQ-004 Parameter DEFAULT_PERIOD, default 13333: period register value after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a frame.
REQ-008 stop  in  1  one-cycle request to abort operation.
REQ-009 mode  in  1  0 = one-shot (single frame), 1 = continuous (frames repeat).
REQ-010 period  in  DIV_W  clock cycles between successive tick starts; sampled only on an accepted start.
REQ-011 sample  out  1  strobe, one cycle per channel per tick.
REQ-012 ch  out  max(1,$clog2(CH))  channel index qualified by sample.
REQ-013 addr  out  $clog2(N)  sample index within the frame, qualified by sample.
REQ-014 run  out  1  high while a frame sequence is active.
REQ-015 frame_done  out  1  one-cycle pulse on the last strobe of a frame.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states SHALL be exactly IDLE, BURST and WAIT.
REQ-018 IDLE: on start=1 and stop=0, the block SHALL latch period (effective period P = max(period, CH)), enter BURST, and assert run the next cycle.
REQ-019 Latency: if start is sampled at edge T, the first strobe (sample=1, ch=0, addr=0) SHALL appear in cycle T+1.
REQ-020 BURST: sample SHALL be high for CH consecutive cycles, with ch = 0..CH-1 in order and addr constant.
REQ-021 After the burst, the block SHALL enter WAIT (sample=0) until P cycles have elapsed since the burst's first cycle; the next burst starts in cycle T+1+k*P for tick k.
REQ-022 When P == CH, WAIT SHALL be skipped and bursts SHALL run back-to-back with sample held high.
REQ-023 After each burst, addr SHALL increment by 1 and wrap from N-1 to 0.
REQ-024 frame_done SHALL be high exactly in the cycle of the strobe with ch=CH-1 and addr=N-1.
REQ-025 One-shot mode: after the frame_done cycle, the block SHALL return to IDLE, with run=0 and sample=0 in the next cycle.
REQ-026 Continuous mode: the block SHALL keep ticking at P with addr wrapping to 0, and frame_done SHALL pulse once per frame.
REQ-027 mode SHALL be sampled at each frame end, so a change takes effect at the next frame boundary.
REQ-028 stop=1 in any state SHALL force IDLE at the next edge: run, sample and frame_done low, addr and ch 0, and no frame_done for the aborted frame.
REQ-029 If start and stop are asserted in the same cycle, stop SHALL win.
REQ-030 start while run=1 SHALL restart the frame: latch the new period, set addr=0 and ch=0, with the first strobe next cycle.
REQ-031 The period counter SHALL be DIV_W bits wide and SHALL never overflow; P up to 2^DIV_W-1 SHALL be supported.

Reset
REQ-032 While rst is high, the block SHALL be in IDLE with sample, run and frame_done at 0, ch and addr at 0, the counter at 0, and the period register at DEFAULT_PERIOD.
REQ-033 Reset asserted mid-burst SHALL clear all outputs immediately (asynchronously), with no partial frame_done.
REQ-034 After rst deasserts, the block SHALL stay in IDLE until the next start.

Verification
REQ-035 N=4, CH=2, mode=0, period=5, start at T: strobes at T+1,2,6,7,11,12,16,17 (ch alternating 0/1, addr 0,0,1,1,2,2,3,3); frame_done only at T+17; run low from T+18.
REQ-036 N=4, CH=1, mode=1, period=3: addr sequence 0,1,2,3,0,1 at 3-cycle spacing; frame_done at addr=3 strobes; run held high.
REQ-037 CH=2, period=0 and period=1: P clamps to 2; sample continuously high, ch toggling every cycle.
REQ-038 stop during WAIT after addr=1 (and stop with start in the same cycle): IDLE next edge, no further strobes, no frame_done.
REQ-039 rst pulse mid-burst, then start with period=4: all outputs 0 during reset; clean frame from addr=0 at 4-cycle spacing.
REQ-040 start re-asserted at addr=2 with a new period: addr restarts at 0 next cycle with the new spacing; no frame_done for the abandoned frame.

Source files
------------

// File: rtl/frame_sampler_if.sv
// Control and strobe bundle for frame_sampler: start/stop/mode/period in,
// registered sample/ch/addr/run/frame_done out.
interface frame_sampler_if #(
  parameter int N     = 16,
  parameter int CH    = 1,
  parameter int DIV_W = 16
);
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int ADDR_W = $clog2(N);

  logic              start;
  logic              stop;
  logic              mode;
  logic [DIV_W-1:0]  period;
  logic              sample;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              frame_done;

  modport master (
    output start, stop, mode, period,
    input  sample, ch, addr, run, frame_done
  );

  modport slave (
    input  start, stop, mode, period,
    output sample, ch, addr, run, frame_done
  );
endinterface

// File: rtl/frame_sampler.sv
// Frame sampler: every P cycles strobes CH channels for one sample index,
// stepping through N indices per frame, one-shot or continuous.
module frame_sampler #(
  parameter int N              = 16,
  parameter int CH             = 1,
  parameter int DIV_W          = 16,
  parameter int DEFAULT_PERIOD = 13333
) (
  input  logic          clk,
  input  logic          rst,
  frame_sampler_if.slave bus
);
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int ADDR_W = $clog2(N);

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
  localparam logic [DIV_W-1:0]  P_MIN     = DIV_W'(CH);

  typedef enum logic [1:0] {IDLE, BURST, WAIT} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sample_q, sample_d;
  logic              run_q, run_d;
  logic              frame_done_q, frame_done_d;

  logic [DIV_W-1:0]  p_eff;
  logic [DIV_W-1:0]  cnt_inc;

  // cnt_q counts cycles since the current burst's first cycle; it stays below P.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    sample_d = 1'b0;

    p_eff   = (bus.period < P_MIN) ? P_MIN : bus.period;
    cnt_inc = cnt_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        ch_d   = '0;
        addr_d = '0;
      end
      BURST: begin
        cnt_d = cnt_inc;
        if (ch_q != CH_LAST) begin
          ch_d     = ch_q + CH_W'(1);
          sample_d = 1'b1;
        end else if (frame_done_q && !bus.mode) begin
          state_d = IDLE;
          cnt_d   = '0;
          ch_d    = '0;
          addr_d  = '0;
        end else begin
          ch_d   = '0;
          addr_d = addr_q + ADDR_W'(1);
          // P == CH: next burst follows immediately, no WAIT cycle.
          if (cnt_inc == period_q) begin
            cnt_d    = '0;
            sample_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_inc == period_q) begin
          state_d  = BURST;
          cnt_d    = '0;
          sample_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // stop outranks start; start from any state (re)launches a frame.
    if (bus.stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ch_d     = '0;
      addr_d   = '0;
      sample_d = 1'b0;
    end else if (bus.start) begin
      state_d  = BURST;
      period_d = p_eff;
      cnt_d    = '0;
      ch_d     = '0;
      addr_d   = '0;
      sample_d = 1'b1;
    end

    run_d        = (state_d != IDLE);
    frame_done_d = sample_d && (ch_d == CH_LAST) && (addr_d == ADDR_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= DIV_W'(DEFAULT_PERIOD);
      cnt_q        <= '0;
      ch_q         <= '0;
      addr_q       <= '0;
      sample_q     <= 1'b0;
      run_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q      <= state_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      sample_q     <= sample_d;
      run_q        <= run_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sample     = sample_q;
  assign bus.ch         = ch_q;
  assign bus.addr       = addr_q;
  assign bus.run        = run_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_frame_sampler.sv
// Scoreboard bench for frame_sampler: dut_a (N=4, CH=2) and dut_b (N=4, CH=1);
// stimulus queues expected strobes, negedge monitors pop and compare.
module tb_frame_sampler;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  frame_sampler_if #(.N(4), .CH(2), .DIV_W(16)) bus_a ();
  frame_sampler_if #(.N(4), .CH(1), .DIV_W(16)) bus_b ();

  frame_sampler #(.N(4), .CH(2), .DIV_W(16), .DEFAULT_PERIOD(13333)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  frame_sampler #(.N(4), .CH(1), .DIV_W(16), .DEFAULT_PERIOD(13333)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    int   cyc;
    int   ch;
    int   addr;
    logic fd;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit sel_b, input int c, input int chn, input int adr, input logic fd);
    exp_t e;
    e.cyc  = c;
    e.ch   = chn;
    e.addr = adr;
    e.fd   = fd;
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitors: every strobe must match the head of the queue in cycle, ch, addr, frame_done.
  always @(negedge clk) begin
    if (bus_a.sample === 1'b1) begin
      if (q_a.size() == 0) begin
        check("unexpected_strobe_a", 32'(bus_a.sample), 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("strobe_cycle_a", cyc, e_a.cyc);
        check("strobe_ch_a", 32'(bus_a.ch), e_a.ch);
        check("strobe_addr_a", 32'(bus_a.addr), e_a.addr);
        check("strobe_fd_a", 32'(bus_a.frame_done), 32'(e_a.fd));
      end
    end else begin
      check("fd_without_strobe_a", 32'(bus_a.frame_done), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus_b.sample === 1'b1) begin
      if (q_b.size() == 0) begin
        check("unexpected_strobe_b", 32'(bus_b.sample), 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("strobe_cycle_b", cyc, e_b.cyc);
        check("strobe_addr_b", 32'(bus_b.addr), e_b.addr);
        check("strobe_fd_b", 32'(bus_b.frame_done), 32'(e_b.fd));
      end
    end else begin
      check("fd_without_strobe_b", 32'(bus_b.frame_done), 32'd0);
    end
  end

  int off_035 [8] = '{1, 2, 6, 7, 11, 12, 16, 17};
  int t;
  int t2;

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.mode = 1'b0; bus_a.period = '0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.mode = 1'b0; bus_b.period = '0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_sample", 32'(bus_a.sample), 32'd0);
    check("rst_run", 32'(bus_a.run), 32'd0);
    check("rst_fd", 32'(bus_a.frame_done), 32'd0);
    check("rst_ch", 32'(bus_a.ch), 32'd0);
    check("rst_addr", 32'(bus_a.addr), 32'd0);
    check("rst_run_b", 32'(bus_b.run), 32'd0);
    rst = 1'b0;
    at_cyc(cyc + 3);
    check("idle_after_rst", 32'(bus_a.run), 32'd0);

    // One-shot, CH=2, period 5: hand-computed strobe cycles.
    bus_a.period = 16'd5; bus_a.mode = 1'b0; bus_a.start = 1'b1; t = cyc;
    for (int i = 0; i < 8; i++) push(1'b0, t + off_035[i], i % 2, i / 2, i == 7);
    @(negedge clk); bus_a.start = 1'b0;
    check("run_first_035", 32'(bus_a.run), 32'd1);
    at_cyc(t + 9);
    check("run_wait_035", 32'(bus_a.run), 32'd1);
    at_cyc(t + 17);
    check("run_last_035", 32'(bus_a.run), 32'd1);
    at_cyc(t + 18);
    check("run_end_035", 32'(bus_a.run), 32'd0);
    check("addr_end_035", 32'(bus_a.addr), 32'd0);
    at_cyc(t + 24);

    // Period 0 clamps to P=2: back-to-back bursts, continuous, stopped after 12 strobes.
    bus_a.period = 16'd0; bus_a.mode = 1'b1; bus_a.start = 1'b1; t = cyc;
    for (int j = 0; j < 12; j++) push(1'b0, t + 1 + j, j % 2, (j / 2) % 4, j == 7);
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t + 12);
    bus_a.stop = 1'b1;
    @(negedge clk); bus_a.stop = 1'b0;
    check("run_after_stop_p0", 32'(bus_a.run), 32'd0);
    at_cyc(t + 18);

    // Period 1 clamps to P=2 as well.
    bus_a.period = 16'd1; bus_a.mode = 1'b1; bus_a.start = 1'b1; t = cyc;
    for (int j = 0; j < 6; j++) push(1'b0, t + 1 + j, j % 2, j / 2, 1'b0);
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t + 6);
    bus_a.stop = 1'b1;
    @(negedge clk); bus_a.stop = 1'b0;
    check("run_after_stop_p1", 32'(bus_a.run), 32'd0);
    at_cyc(t + 12);

    // Stop during WAIT after addr=1 burst.
    bus_a.period = 16'd5; bus_a.mode = 1'b0; bus_a.start = 1'b1; t = cyc;
    push(1'b0, t + 1, 0, 0, 1'b0); push(1'b0, t + 2, 1, 0, 1'b0);
    push(1'b0, t + 6, 0, 1, 1'b0); push(1'b0, t + 7, 1, 1, 1'b0);
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t + 8);
    check("run_in_wait", 32'(bus_a.run), 32'd1);
    bus_a.stop = 1'b1;
    @(negedge clk); bus_a.stop = 1'b0;
    check("run_after_wait_stop", 32'(bus_a.run), 32'd0);
    check("addr_after_wait_stop", 32'(bus_a.addr), 32'd0);
    at_cyc(t + 24);

    // start and stop together: stop wins.
    bus_a.period = 16'd5; bus_a.start = 1'b1; bus_a.stop = 1'b1;
    @(negedge clk); bus_a.start = 1'b0; bus_a.stop = 1'b0;
    check("run_start_stop", 32'(bus_a.run), 32'd0);
    at_cyc(cyc + 8);

    // Async reset mid-burst, then a clean frame at period 4.
    bus_a.period = 16'd5; bus_a.mode = 1'b0; bus_a.start = 1'b1; t = cyc;
    push(1'b0, t + 1, 0, 0, 1'b0);
    @(negedge clk); bus_a.start = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_sample", 32'(bus_a.sample), 32'd0);
    check("async_rst_run", 32'(bus_a.run), 32'd0);
    check("async_rst_fd", 32'(bus_a.frame_done), 32'd0);
    @(negedge clk); @(negedge clk);
    check("held_rst_run", 32'(bus_a.run), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_a.period = 16'd4; bus_a.mode = 1'b0; bus_a.start = 1'b1; t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, t + 1 + 4 * k, 0, k, 1'b0);
      push(1'b0, t + 2 + 4 * k, 1, k, k == 3);
    end
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t + 15);
    check("run_end_p4", 32'(bus_a.run), 32'd0);
    at_cyc(t + 20);

    // Restart at addr=2 with period 3; abandoned frame gives no frame_done.
    bus_a.period = 16'd5; bus_a.mode = 1'b0; bus_a.start = 1'b1; t = cyc;
    push(1'b0, t + 1, 0, 0, 1'b0); push(1'b0, t + 2, 1, 0, 1'b0);
    push(1'b0, t + 6, 0, 1, 1'b0); push(1'b0, t + 7, 1, 1, 1'b0);
    push(1'b0, t + 11, 0, 2, 1'b0);
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t + 11);
    bus_a.period = 16'd3; bus_a.start = 1'b1; t2 = cyc;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, t2 + 1 + 3 * k, 0, k, 1'b0);
      push(1'b0, t2 + 2 + 3 * k, 1, k, k == 3);
    end
    @(negedge clk); bus_a.start = 1'b0;
    at_cyc(t2 + 12);
    check("run_end_restart", 32'(bus_a.run), 32'd0);
    at_cyc(t2 + 16);

    // dut_b: CH=1 continuous at period 3; mode drops to one-shot during frame 2.
    bus_b.period = 16'd3; bus_b.mode = 1'b1; bus_b.start = 1'b1; t = cyc;
    for (int k = 0; k < 8; k++) push(1'b1, t + 1 + 3 * k, 0, k % 4, (k % 4) == 3);
    @(negedge clk); bus_b.start = 1'b0;
    at_cyc(t + 11);
    check("run_b_frame_boundary", 32'(bus_b.run), 32'd1);
    at_cyc(t + 12);
    bus_b.mode = 1'b0;
    at_cyc(t + 20);
    check("run_b_frame2", 32'(bus_b.run), 32'd1);
    at_cyc(t + 23);
    check("run_b_end", 32'(bus_b.run), 32'd0);
    at_cyc(t + 28);

    check("pending_a", q_a.size(), 32'd0);
    check("pending_b", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
